// File: rtl/des_key_sched_seq.sv
// DES key schedule sequencer: loads a 64-bit key and streams its 16 round keys
// over a valid/ready handshake, in decryption (K16..K1) or encryption order.
module des_key_sched_seq #(
  parameter bit DECRYPT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        abort,
  output logic [47:0] rk,
  output logic [3:0]  rk_idx,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic        rk_last
);

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned CD_W   = 56;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned RK_W   = 48;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned RND_W  = 5;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ROUND = 1'b1;

  // Tables use FIPS 1-based bit numbering (bit 1 = MSB)
  localparam int unsigned PC1_TBL [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [RK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CD_W); i++) begin
      r[6'(int'(CD_W) - 1 - i)] = k[6'(KEY_W - PC1_TBL[i])];
    end
    return r;
  endfunction

  function automatic logic [RK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [RK_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(RK_W); i++) begin
      r[6'(int'(RK_W) - 1 - i)] = cd[6'(CD_W - PC2_TBL[i])];
    end
    return r;
  endfunction

  // High when the shift amount s(r) is 2 rather than 1
  function automatic logic shift_two(input logic [RND_W-1:0] r);
    return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
  endfunction

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
  endfunction

  logic [0:0]        state_q, state_nx;
  logic [IDX_W-1:0]  n_q, n_nx;
  logic [HALF_W-1:0] c_q, c_nx, d_q, d_nx;
  logic              key_ready_nx, rk_valid_nx, rk_last_nx;
  logic [IDX_W-1:0]  rk_idx_nx;
  logic [CD_W-1:0]   pc1_key;
  logic [RND_W-1:0]  dec_rnd, enc_rnd;

  assign pc1_key = pc1(key);
  assign dec_rnd = 5'd16 - RND_W'(n_q);
  assign enc_rnd = RND_W'(n_q) + 5'd2;
  assign rk      = pc2({c_q, d_q});

  // Next-state and next-output logic
  always_comb begin
    state_nx     = state_q;
    n_nx         = n_q;
    c_nx         = c_q;
    d_nx         = d_q;
    key_ready_nx = key_ready;
    rk_valid_nx  = rk_valid;
    rk_idx_nx    = rk_idx;
    rk_last_nx   = rk_last;
    case (state_q)
      ST_IDLE: begin
        if (key_valid && key_ready) begin
          state_nx     = ST_ROUND;
          n_nx         = '0;
          key_ready_nx = 1'b0;
          rk_valid_nx  = 1'b1;
          rk_last_nx   = 1'b0;
          // C16D16 equals C0D0, so decryption starts from the unrotated halves
          if (DECRYPT) begin
            c_nx      = pc1_key[CD_W-1:HALF_W];
            d_nx      = pc1_key[HALF_W-1:0];
            rk_idx_nx = 4'd15;
          end else begin
            c_nx      = rotl(pc1_key[CD_W-1:HALF_W], 1'b0);
            d_nx      = rotl(pc1_key[HALF_W-1:0], 1'b0);
            rk_idx_nx = 4'd0;
          end
        end
      end
      ST_ROUND: begin
        if (abort || (rk_ready && n_q == 4'd15)) begin
          state_nx     = ST_IDLE;
          key_ready_nx = 1'b1;
          rk_valid_nx  = 1'b0;
          rk_last_nx   = 1'b0;
        end else if (rk_ready) begin
          n_nx       = IDX_W'(n_q + 4'd1);
          rk_last_nx = (n_q == 4'd14);
          if (DECRYPT) begin
            c_nx      = rotr(c_q, shift_two(dec_rnd));
            d_nx      = rotr(d_q, shift_two(dec_rnd));
            rk_idx_nx = IDX_W'(rk_idx - 4'd1);
          end else begin
            c_nx      = rotl(c_q, shift_two(enc_rnd));
            d_nx      = rotl(d_q, shift_two(enc_rnd));
            rk_idx_nx = IDX_W'(rk_idx + 4'd1);
          end
        end
      end
      default: begin
        state_nx     = ST_IDLE;
        key_ready_nx = 1'b1;
        rk_valid_nx  = 1'b0;
        rk_last_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_idx    <= '0;
      rk_last   <= 1'b0;
    end else begin
      state_q   <= state_nx;
      n_q       <= n_nx;
      c_q       <= c_nx;
      d_q       <= d_nx;
      key_ready <= key_ready_nx;
      rk_valid  <= rk_valid_nx;
      rk_idx    <= rk_idx_nx;
      rk_last   <= rk_last_nx;
    end
  end

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Bench for des_key_sched_seq: decrypt- and encrypt-order instances share
// stimulus; a scoreboard fed from a from-scratch key schedule model checks rk.
module tb_des_key_sched_seq;

  typedef struct packed {
    logic [47:0] rk;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] key;
  logic        key_valid, abort, rk_ready;
  logic        key_ready_d, rk_valid_d, rk_last_d;
  logic [47:0] rk_d;
  logic [3:0]  idx_d;
  logic        key_ready_e, rk_valid_e, rk_last_e;
  logic [47:0] rk_e;
  logic [3:0]  idx_e;

  int n_checks = 0;
  int n_bad    = 0;

  exp_t q_dec[$];
  exp_t q_enc[$];

  logic        prev_stall = 1'b0;
  logic [47:0] prev_rk;
  logic [3:0]  prev_idx;
  logic        prev_last;

  always #5 clk = ~clk;

  des_key_sched_seq #(.DECRYPT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .key_ready(key_ready_d),
    .abort(abort), .rk(rk_d), .rk_idx(idx_d), .rk_valid(rk_valid_d), .rk_ready(rk_ready),
    .rk_last(rk_last_d)
  );

  des_key_sched_seq #(.DECRYPT(1'b0)) dut_enc (
    .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .key_ready(key_ready_e),
    .abort(abort), .rk(rk_e), .rk_idx(idx_e), .rk_valid(rk_valid_e), .rk_ready(rk_ready),
    .rk_last(rk_last_e)
  );

  // Round key r (1..16) computed directly: C0D0 rotated by the cumulative shift
  function automatic logic [47:0] ref_key(input logic [63:0] k, input int r);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] o;
    int sh;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - PC1[i])];
    c = cd[55:28];
    d = cd[27:0];
    sh = 0;
    for (int j = 1; j <= r; j++) sh += (j == 1 || j == 2 || j == 9 || j == 16) ? 1 : 2;
    for (int j = 0; j < sh; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return o;
  endfunction

  function automatic void push_sched(input logic [63:0] k);
    exp_t e;
    for (int j = 0; j < 16; j++) begin
      e.rk = ref_key(k, 16 - j); e.idx = 4'(15 - j); e.last = (j == 15);
      q_dec.push_back(e);
      e.rk = ref_key(k, j + 1);  e.idx = 4'(j);      e.last = (j == 15);
      q_enc.push_back(e);
    end
  endfunction

  // Scoreboard: pushes on key acceptance, pops on each rk handshake
  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      q_dec.delete();
      q_enc.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if ({rk_valid_d, rk_d, idx_d, rk_last_d} !== {1'b1, prev_rk, prev_idx, prev_last}) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%b rk=%h idx=%0d last=%b want v=1 rk=%h idx=%0d last=%b",
                   rk_valid_d, rk_d, idx_d, rk_last_d, prev_rk, prev_idx, prev_last);
        end
      end
      prev_stall = rk_valid_d && !rk_ready && !abort;
      prev_rk = rk_d; prev_idx = idx_d; prev_last = rk_last_d;
      if (rk_valid_d && abort) begin
        q_dec.delete();
        q_enc.delete();
      end else if (rk_valid_d && rk_ready) begin
        n_checks++;
        if (q_dec.size() == 0) begin
          n_bad++;
          $display("FAIL dec_extra_key: got rk=%h idx=%0d, want no key", rk_d, idx_d);
        end else begin
          e = q_dec.pop_front();
          if ({rk_d, idx_d, rk_last_d} !== e) begin
            n_bad++;
            $display("FAIL dec_key: got rk=%h idx=%0d last=%b want rk=%h idx=%0d last=%b",
                     rk_d, idx_d, rk_last_d, e.rk, e.idx, e.last);
          end
        end
        n_checks++;
        if (q_enc.size() == 0) begin
          n_bad++;
          $display("FAIL enc_extra_key: got rk=%h idx=%0d, want no key", rk_e, idx_e);
        end else begin
          e = q_enc.pop_front();
          if ({rk_valid_e, rk_e, idx_e, rk_last_e} !== {1'b1, e}) begin
            n_bad++;
            $display("FAIL enc_key: got v=%b rk=%h idx=%0d last=%b want v=1 rk=%h idx=%0d last=%b",
                     rk_valid_e, rk_e, idx_e, rk_last_e, e.rk, e.idx, e.last);
          end
          if (e.last) begin
            n_checks++;
            if (q_enc.size() != 0) begin
              n_bad++;
              $display("FAIL sched_len: got %0d keys left after last, want 0", q_enc.size());
            end
          end
        end
      end
      if (key_valid && key_ready_d) push_sched(key);
    end
  end

  // Stimulus: offer a key until accepted; called just after a rising edge
  task automatic offer_key(input logic [63:0] k, input bit hold, output bit acc);
    key = k;
    key_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (key_ready_d) acc = 1'b1;
    end
    @(posedge clk); #1;
    if (!hold) key_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd, output bit done);
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk); #1;
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (q_dec.size() == 0 && key_ready_d && !rk_valid_d) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key = '0; key_valid = 1'b0; abort = 1'b0; rk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({key_ready_d, rk_valid_d, rk_last_d, idx_d, rk_d} !== {1'b1, 1'b0, 1'b0, 4'd0, 48'd0}) begin
      n_bad++;
      $display("FAIL reset_dec: got kr=%b v=%b last=%b idx=%0d rk=%h want 1 0 0 0 0",
               key_ready_d, rk_valid_d, rk_last_d, idx_d, rk_d);
    end
    n_checks++;
    if ({key_ready_e, rk_valid_e, rk_last_e, idx_e, rk_e} !== {1'b1, 1'b0, 1'b0, 4'd0, 48'd0}) begin
      n_bad++;
      $display("FAIL reset_enc: got kr=%b v=%b last=%b idx=%0d rk=%h want 1 0 0 0 0",
               key_ready_e, rk_valid_e, rk_last_e, idx_e, rk_e);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_known_answer();
    logic [47:0] ds [16];
    logic [47:0] es [16];
    logic [3:0]  di [16];
    logic [3:0]  ei [16];
    logic        dl [16];
    logic        el [16];
    int nv;
    bit acc;
    rk_ready = 1'b1;
    offer_key(64'h133457799BBCDFF1, 1'b0, acc);
    nv = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      ds[j] = rk_d; di[j] = idx_d; dl[j] = rk_last_d;
      es[j] = rk_e; ei[j] = idx_e; el[j] = rk_last_e;
      if (rk_valid_d && rk_valid_e) nv++;
    end
    n_checks++;
    if (!acc || nv != 16) begin
      n_bad++;
      $display("FAIL kat_consecutive: got acc=%b valid_cycles=%0d want 1 16", acc, nv);
    end
    n_checks++;
    if ({ds[0], di[0], dl[0]} !== {48'hCB3D8B0E17F5, 4'd15, 1'b0}) begin
      n_bad++;
      $display("FAIL kat_dec_first: got %h/%0d/%b want cb3d8b0e17f5/15/0", ds[0], di[0], dl[0]);
    end
    n_checks++;
    if (ds[14] !== 48'h79AED9DBC9E5) begin
      n_bad++;
      $display("FAIL kat_dec_k2: got %h want 79aed9dbc9e5", ds[14]);
    end
    n_checks++;
    if ({ds[15], di[15], dl[15]} !== {48'h1B02EFFC7072, 4'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL kat_dec_last: got %h/%0d/%b want 1b02effc7072/0/1", ds[15], di[15], dl[15]);
    end
    n_checks++;
    if ({es[0], ei[0], es[1], ei[1]} !== {48'h1B02EFFC7072, 4'd0, 48'h79AED9DBC9E5, 4'd1}) begin
      n_bad++;
      $display("FAIL kat_enc_first: got %h/%0d %h/%0d want 1b02effc7072/0 79aed9dbc9e5/1",
               es[0], ei[0], es[1], ei[1]);
    end
    n_checks++;
    if ({es[15], ei[15], el[15]} !== {48'hCB3D8B0E17F5, 4'd15, 1'b1}) begin
      n_bad++;
      $display("FAIL kat_enc_last: got %h/%0d/%b want cb3d8b0e17f5/15/1", es[15], ei[15], el[15]);
    end
    for (int j = 0; j < 16; j++) begin
      n_checks++;
      if (es[j] !== ds[15 - j]) begin
        n_bad++;
        $display("FAIL kat_reverse[%0d]: got %h want %h", j, es[j], ds[15 - j]);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({key_ready_d, rk_valid_d, rk_last_d} !== 3'b100) begin
      n_bad++;
      $display("FAIL kat_idle_after: got kr=%b v=%b last=%b want 1 0 0", key_ready_d, rk_valid_d, rk_last_d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stalls();
    bit acc, done;
    for (int t = 0; t < 3; t++) begin
      offer_key({$urandom, $urandom}, 1'b0, acc);
      drain(1'b1, done);
      n_checks++;
      if (!acc || !done) begin
        n_bad++;
        $display("FAIL stalls_complete[%0d]: got acc=%b done=%b left=%0d want 1 1 0", t, acc, done, q_dec.size());
      end
    end
  endtask

  task automatic test_abort();
    bit acc, done;
    rk_ready = 1'b1;
    offer_key(64'h0E329232EA6D0D73, 1'b0, acc);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({acc, key_ready_d, rk_valid_d, key_ready_e, rk_valid_e} !== 5'b11010) begin
      n_bad++;
      $display("FAIL abort_idle: got acc=%b kr=%b v=%b kr_e=%b v_e=%b want 1 1 0 1 0",
               acc, key_ready_d, rk_valid_d, key_ready_e, rk_valid_e);
    end
    @(posedge clk); #1 abort = 1'b1;
    offer_key(64'h3B3898371520F75E, 1'b0, acc);
    abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({acc, rk_valid_d, idx_d, rk_d} !== {1'b1, 1'b1, 4'd15, ref_key(64'h3B3898371520F75E, 16)}) begin
      n_bad++;
      $display("FAIL abort_idle_load: got acc=%b v=%b idx=%0d rk=%h want 1 1 15 %h",
               acc, rk_valid_d, idx_d, rk_d, ref_key(64'h3B3898371520F75E, 16));
    end
    drain(1'b0, done);
    n_checks++;
    if (!done) begin
      n_bad++;
      $display("FAIL abort_followup: got done=0 left=%0d want done=1", q_dec.size());
    end
  endtask

  task automatic test_reset_mid();
    bit acc, done;
    rk_ready = 1'b1;
    offer_key(64'hAABB09182736CCDD, 1'b0, acc);
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if ({acc, rk_valid_d, idx_d} !== {1'b1, 1'b1, 4'd8}) begin
      n_bad++;
      $display("FAIL midrst_round8: got acc=%b v=%b idx=%0d want 1 1 8", acc, rk_valid_d, idx_d);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({key_ready_d, rk_valid_d, rk_last_d, idx_d, rk_d, key_ready_e, rk_valid_e, idx_e, rk_e}
        !== {1'b1, 1'b0, 1'b0, 4'd0, 48'd0, 1'b1, 1'b0, 4'd0, 48'd0}) begin
      n_bad++;
      $display("FAIL midrst_async: got kr=%b v=%b last=%b idx=%0d rk=%h enc idx=%0d rk=%h want 1 0 0 0 0 0 0",
               key_ready_d, rk_valid_d, rk_last_d, idx_d, rk_d, idx_e, rk_e);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    offer_key(64'h0123456789ABCDEF, 1'b0, acc);
    drain(1'b1, done);
    n_checks++;
    if (!acc || !done) begin
      n_bad++;
      $display("FAIL midrst_followup: got acc=%b done=%b want 1 1", acc, done);
    end
  endtask

  task automatic test_back_to_back();
    bit acc, done;
    int early;
    logic [63:0] kb;
    kb = 64'hFEDCBA9876543210;
    rk_ready = 1'b1;
    offer_key(64'h1122334455667788, 1'b1, acc);
    key = kb;
    early = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (key_ready_d || !rk_valid_d) early++;
    end
    @(negedge clk);
    n_checks++;
    if ({acc, early != 0, key_ready_d, rk_valid_d} !== 4'b1010) begin
      n_bad++;
      $display("FAIL b2b_final: got acc=%b bad_cycles=%0d kr=%b v=%b want 1 0 1 0",
               acc, early, key_ready_d, rk_valid_d);
    end
    @(posedge clk); #1 key_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rk_valid_d, idx_d, rk_d} !== {1'b1, 4'd15, ref_key(kb, 16)}) begin
      n_bad++;
      $display("FAIL b2b_second_first: got v=%b idx=%0d rk=%h want 1 15 %h",
               rk_valid_d, idx_d, rk_d, ref_key(kb, 16));
    end
    drain(1'b0, done);
    n_checks++;
    if (!done) begin
      n_bad++;
      $display("FAIL b2b_drain: got done=0 left=%0d want done=1", q_dec.size());
    end
  endtask

  initial begin
    test_reset();
    test_known_answer();
    test_stalls();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
